first_channel_sync: RTL and testbench
=====================================

FIRST_CHANNEL_SYNC -- requirements
Module: first_channel_sync

Interface
REQ-001 Parameter DATA_W, default 24: data word width, 8 or greater.
REQ-002 Parameter MATCH_LEN, default 4: consecutive marker beats that form a marker burst, range 1..15.
REQ-003 Parameter MARKER_A, default 8'hB8: first accepted marker value.
REQ-004 Parameter MARKER_B, default 8'hF8: second accepted marker value.
REQ-005 Parameter MARKER_MASK, default 8'hFF: bit mask applied to data_in[7:0], MARKER_A and MARKER_B before comparison.
REQ-006 Parameter NUM_CH, default 256: channel beats per frame between marker bursts, 2 or greater.
REQ-007 Parameter MISS_LIMIT, default 2: consecutive failed marker checks before lock is dropped, 1 or greater.
REQ-008 clk  in  1  single clock; all logic on its rising edge.
REQ-009 rst  in  1  reset, synchronous and active-high.
REQ-010 in_valid  in  1  data_in holds a beat this cycle.
REQ-011 data_in  in  DATA_W  aligned ADC word.
REQ-012 out_valid  out  1  in_valid delayed by 1 cycle.
REQ-013 data_out  out  DATA_W  data_in delayed by 1 cycle, loaded only on accepted beats.
REQ-014 first_sample_pulse  out  1  1-cycle pulse on the out beat that completes a marker burst.
REQ-015 ch_valid  out  1  out beat is a channel-data beat.
REQ-016 ch_idx  out  $clog2(NUM_CH)  channel index of the current out beat, valid when ch_valid is high.
REQ-017 locked  out  1  high in DATA and CHECK states.
REQ-018 lock_lost_pulse  out  1  1-cycle pulse when lock is dropped.

Function
REQ-019 Beat acceptance: a beat is accepted when in_valid=1; idle cycles leave all state, counters and the run count unchanged.
REQ-020 Marker test: (data_in[7:0]&MARKER_MASK) equals (MARKER_A&MARKER_MASK) or (MARKER_B&MARKER_MASK).
REQ-021 All outputs are registered, with latency of exactly 1 cycle from the accepted beat.
REQ-022 SEARCH state:
  - accepted marker increments run; accepted non-marker clears run;
  - when the marker beat brings run to MATCH_LEN: assert first_sample_pulse, clear run and ch_cnt, go to DATA.
REQ-023 DATA state:
  - each accepted beat asserts ch_valid with ch_idx=ch_cnt, then increments ch_cnt;
  - the beat with ch_cnt=NUM_CH-1 moves to CHECK and clears run;
  - marker values in DATA are treated as plain data.
REQ-024 CHECK state, accepted marker:
  - increments run;
  - when run reaches MATCH_LEN: assert first_sample_pulse, clear miss_cnt and ch_cnt, go to DATA.
REQ-025 CHECK state, accepted non-marker:
  - clears run and increments miss_cnt;
  - when miss_cnt reaches MISS_LIMIT: go to SEARCH, assert lock_lost_pulse, clear miss_cnt;
  - otherwise remain in CHECK.
REQ-026 ch_valid is never asserted on marker-burst beats or in SEARCH.
REQ-027 first_sample_pulse and ch_valid are never high in the same cycle.
REQ-028 MATCH_LEN=1: a single marker beat completes the burst.

Reset
REQ-029 On rst=1 at a clock edge, the block enters SEARCH and clears run, ch_cnt and miss_cnt; all outputs go to 0, including data_out=0 and ch_idx=0.
REQ-030 rst overrides any concurrent beat, and a reset in the middle of a frame or burst discards all partial progress.

Configuration
REQ-031 Macro FCS_STATS_EN, when defined, adds two outputs, both cleared by reset:
  - frame_cnt[15:0]: counts first_sample_pulse events;
  - lock_loss_cnt[15:0]: counts lock_lost_pulse events;
  - both saturate at 16'hFFFF.
REQ-032 Without FCS_STATS_EN, these ports and their counters are absent, and all other behaviour is identical.

Verification (bench parameters: NUM_CH=4, MATCH_LEN=4, MISS_LIMIT=2)
REQ-033 Run 10 random non-marker beats, then 4 beats ending 0xB8 -> first_sample_pulse=1 on the 4th marker out beat; locked=1 on the next cycle.
REQ-034 Achieve lock, then send 4 data beats followed by 4 beats ending 0xF8 -> ch_idx 0,1,2,3 with ch_valid; pulse on the last marker; no lock_lost_pulse.
REQ-035 In SEARCH, send 3 beats ending 0xF8, then 0x00, then 3 beats ending 0xB8 -> no pulse; run restarts after the 0x00 beat.
REQ-036 Send 0xB8 beats separated by in_valid=0 gaps of 3 cycles -> pulse on the 4th accepted marker; gaps do not reset run.
REQ-037 While locked, send 2 consecutive non-marker beats in CHECK -> lock_lost_pulse=1, locked=0, SEARCH; with FCS_STATS_EN, lock_loss_cnt=1.
REQ-038 Assert rst in the middle of DATA at ch_idx=2 -> all outputs are 0 on the next cycle; 4 new markers are required to relock.

Source files
------------

// File: rtl/first_channel_sync.sv
// Frame aligner: finds a burst of MATCH_LEN marker beats, then labels the next NUM_CH beats as channels 0..NUM_CH-1.
// All outputs are registered one cycle after the accepted beat. Optional FCS_STATS_EN macro adds frame/lock-loss counters.
module first_channel_sync #(
  parameter int          DATA_W      = 24,
  parameter int          MATCH_LEN   = 4,
  parameter logic [7:0]  MARKER_A    = 8'hB8,
  parameter logic [7:0]  MARKER_B    = 8'hF8,
  parameter logic [7:0]  MARKER_MASK = 8'hFF,
  parameter int          NUM_CH      = 256,
  parameter int          MISS_LIMIT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         data_out,
  output logic                      first_sample_pulse,
  output logic                      ch_valid,
  output logic [$clog2(NUM_CH)-1:0] ch_idx,
  output logic                      locked,
  output logic                      lock_lost_pulse
`ifdef FCS_STATS_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               lock_loss_cnt
`endif
);

  localparam int CW = $clog2(NUM_CH);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;

  logic [1:0]        r_state, w_state_nx;
  logic [3:0]        r_run, w_run_nx;
  logic [CW-1:0]     r_ch_cnt, w_ch_nx;
  logic [MW-1:0]     r_miss, w_miss_nx;

  logic              r_out_valid, r_fsp, r_chv, r_lost;
  logic [DATA_W-1:0] r_data;
  logic [CW-1:0]     r_ch_idx;

  logic              w_fsp_nx, w_chv_nx, w_lost_nx;
  logic              w_mark, w_run_hit, w_miss_hit, w_last_ch;
  logic [3:0]        w_run_inc;
  logic [MW-1:0]     w_miss_inc;

  assign w_mark = ((data_in[7:0] & MARKER_MASK) == (MARKER_A & MARKER_MASK)) ||
                  ((data_in[7:0] & MARKER_MASK) == (MARKER_B & MARKER_MASK));

  assign w_run_inc  = r_run + 4'd1;
  assign w_run_hit  = (w_run_inc == 4'(MATCH_LEN));
  assign w_miss_inc = r_miss + 1'b1;
  assign w_miss_hit = (w_miss_inc == MW'(MISS_LIMIT));
  assign w_last_ch  = (r_ch_cnt == CW'(NUM_CH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_run       <= '0;
      r_ch_cnt    <= '0;
      r_miss      <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_fsp       <= 1'b0;
      r_chv       <= 1'b0;
      r_ch_idx    <= '0;
      r_lost      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_run       <= w_run_nx;
      r_ch_cnt    <= w_ch_nx;
      r_miss      <= w_miss_nx;
      r_out_valid <= in_valid;
      r_fsp       <= w_fsp_nx;
      r_chv       <= w_chv_nx;
      r_lost      <= w_lost_nx;
      if (in_valid) r_data   <= data_in;
      if (w_chv_nx) r_ch_idx <= r_ch_cnt;
    end
  end

  // Idle cycles (in_valid=0) freeze every counter, so gaps never break a burst.
  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    w_ch_nx    = r_ch_cnt;
    w_miss_nx  = r_miss;
    if (in_valid) begin
      case (r_state)
        S_SEARCH: begin
          if (!w_mark) begin
            w_run_nx = '0;
          end else if (w_run_hit) begin
            w_state_nx = S_DATA;
            w_run_nx   = '0;
            w_ch_nx    = '0;
          end else begin
            w_run_nx = w_run_inc;
          end
        end
        S_DATA: begin
          if (w_last_ch) begin
            w_state_nx = S_CHECK;
            w_run_nx   = '0;
            w_ch_nx    = '0;
          end else begin
            w_ch_nx = r_ch_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_mark) begin
            if (w_run_hit) begin
              w_state_nx = S_DATA;
              w_run_nx   = '0;
              w_miss_nx  = '0;
              w_ch_nx    = '0;
            end else begin
              w_run_nx = w_run_inc;
            end
          end else begin
            w_run_nx = '0;
            if (w_miss_hit) begin
              w_state_nx = S_SEARCH;
              w_miss_nx  = '0;
            end else begin
              w_miss_nx = w_miss_inc;
            end
          end
        end
        default: begin
          w_state_nx = S_SEARCH;
          w_run_nx   = '0;
          w_ch_nx    = '0;
          w_miss_nx  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_fsp_nx  = 1'b0;
    w_chv_nx  = 1'b0;
    w_lost_nx = 1'b0;
    if (in_valid) begin
      w_fsp_nx  = w_mark && w_run_hit && (r_state == S_SEARCH || r_state == S_CHECK);
      w_chv_nx  = (r_state == S_DATA);
      w_lost_nx = (r_state == S_CHECK) && !w_mark && w_miss_hit;
    end
  end

  assign out_valid          = r_out_valid;
  assign data_out           = r_data;
  assign first_sample_pulse = r_fsp;
  assign ch_valid           = r_chv;
  assign ch_idx             = r_ch_idx;
  assign locked             = (r_state == S_DATA) || (r_state == S_CHECK);
  assign lock_lost_pulse    = r_lost;

`ifdef FCS_STATS_EN
  logic [15:0] r_frame_cnt, r_lock_loss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt     <= '0;
      r_lock_loss_cnt <= '0;
    end else begin
      if (w_fsp_nx && r_frame_cnt != 16'hFFFF)      r_frame_cnt     <= r_frame_cnt + 16'd1;
      if (w_lost_nx && r_lock_loss_cnt != 16'hFFFF) r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
    end
  end

  assign frame_cnt     = r_frame_cnt;
  assign lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule

// File: tb/tb_first_channel_sync.sv
// Randomized bench for first_channel_sync with a frame-position reference model.
module tb_first_channel_sync;
  localparam int DATA_W = 24, NUM_CH = 4, MATCH_LEN = 4, MISS_LIMIT = 2;
  localparam int CW = $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              out_valid, first_sample_pulse, ch_valid, locked, lock_lost_pulse;
  logic [DATA_W-1:0] data_out;
  logic [CW-1:0]     ch_idx;
`ifdef FCS_STATS_EN
  logic [15:0]       frame_cnt, lock_loss_cnt;
`endif

  first_channel_sync #(.DATA_W(DATA_W), .MATCH_LEN(MATCH_LEN), .NUM_CH(NUM_CH),
                       .MISS_LIMIT(MISS_LIMIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .first_sample_pulse(first_sample_pulse),
    .ch_valid(ch_valid), .ch_idx(ch_idx), .locked(locked), .lock_lost_pulse(lock_lost_pulse)
`ifdef FCS_STATS_EN
    , .frame_cnt(frame_cnt), .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: m_pos = -1 hunting, 0..NUM_CH-1 next channel expected, NUM_CH awaiting marker burst.
  int m_pos, m_run, m_miss, m_frames, m_losses;
  logic              e_ov, e_fsp, e_chv, e_lost, e_lock;
  logic [CW-1:0]     e_idx;
  logic [DATA_W-1:0] e_dout;

  function automatic logic is_marker(logic [DATA_W-1:0] d);
    return d[7:0] == 8'hB8 || d[7:0] == 8'hF8;
  endfunction

  function automatic logic [DATA_W-1:0] nonmark();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    if (is_marker(d)) d[0] = 1'b1;
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] mark(logic [7:0] lo);
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    d[7:0] = lo;
    return d;
  endfunction

  task automatic model_reset();
    m_pos = -1; m_run = 0; m_miss = 0; m_frames = 0; m_losses = 0;
    e_ov = 0; e_fsp = 0; e_chv = 0; e_lost = 0; e_lock = 0; e_idx = '0; e_dout = '0;
  endtask

  task automatic model_step(logic v, logic [DATA_W-1:0] d);
    e_ov = v; e_fsp = 0; e_chv = 0; e_lost = 0;
    if (v) begin
      e_dout = d;
      if (m_pos < 0 || m_pos == NUM_CH) begin
        if (is_marker(d)) begin
          m_run++;
          if (m_run == MATCH_LEN) begin
            e_fsp = 1; m_run = 0; m_miss = 0; m_pos = 0; m_frames++;
          end
        end else begin
          m_run = 0;
          if (m_pos == NUM_CH) begin
            m_miss++;
            if (m_miss == MISS_LIMIT) begin
              e_lost = 1; m_miss = 0; m_pos = -1; m_losses++;
            end
          end
        end
      end else begin
        e_chv = 1; e_idx = CW'(m_pos); m_pos++;
        if (m_pos == NUM_CH) m_run = 0;
      end
    end
    e_lock = (m_pos >= 0);
  endtask

  // Present one cycle of input, then sample outputs 1 time unit after the edge.
  task automatic drive(logic v, logic [DATA_W-1:0] d);
    in_valid = v; data_in = d;
    @(posedge clk);
    model_step(v, d);
    #1;
  endtask

  task automatic do_reset(logic v, logic [DATA_W-1:0] d);
    rst = 1; in_valid = v; data_in = d;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0; in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b1, mark(8'hB8));
    n_cmp++; if ({out_valid, first_sample_pulse, ch_valid, locked, lock_lost_pulse} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b expected 00000",
        {out_valid, first_sample_pulse, ch_valid, locked, lock_lost_pulse}); end
    n_cmp++; if (data_out !== '0 || ch_idx !== '0) begin
      n_err++; $display("FAIL reset_data got dout=%0h idx=%0d expected 0/0", data_out, ch_idx); end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 10; i++) drive(1'b1, nonmark());
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_pre got %b expected 0", locked); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mark(8'hB8));
      n_cmp++; if (first_sample_pulse !== (i == 3)) begin
        n_err++; $display("FAIL lock_pulse[%0d] got %b expected %b", i, first_sample_pulse, i == 3); end
    end
    drive(1'b0, '0);
    n_cmp++; if (locked !== 1'b1 || first_sample_pulse !== 1'b0) begin
      n_err++; $display("FAIL lock_after got locked=%b fsp=%b expected 1/0", locked, first_sample_pulse); end
  endtask

  task automatic test_frame();
    for (int i = 0; i < NUM_CH; i++) begin
      drive(1'b1, (i < 2) ? mark(8'hB8) : nonmark());
      n_cmp++; if (ch_valid !== 1'b1 || ch_idx !== CW'(i) || first_sample_pulse !== 1'b0) begin
        n_err++; $display("FAIL frame_ch[%0d] got chv=%b idx=%0d fsp=%b expected 1/%0d/0",
          i, ch_valid, ch_idx, first_sample_pulse, i); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mark(8'hF8));
      n_cmp++; if (first_sample_pulse !== (i == 3) || ch_valid !== 1'b0 || lock_lost_pulse !== 1'b0) begin
        n_err++; $display("FAIL frame_burst[%0d] got fsp=%b chv=%b lost=%b expected %b/0/0",
          i, first_sample_pulse, ch_valid, lock_lost_pulse, i == 3); end
    end
  endtask

  task automatic test_partial();
    logic [DATA_W-1:0] seq [8];
    do_reset(1'b0, '0);
    for (int i = 0; i < 3; i++) seq[i] = mark(8'hF8);
    seq[3] = '0;
    for (int i = 4; i < 8; i++) seq[i] = mark(8'hB8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq[i]);
      n_cmp++; if (first_sample_pulse !== (i == 7)) begin
        n_err++; $display("FAIL partial[%0d] got %b expected %b", i, first_sample_pulse, i == 7); end
    end
  endtask

  task automatic test_gaps();
    do_reset(1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mark(8'hB8));
      n_cmp++; if (first_sample_pulse !== (i == 3) || out_valid !== 1'b1) begin
        n_err++; $display("FAIL gap_beat[%0d] got fsp=%b ov=%b expected %b/1", i, first_sample_pulse, out_valid, i == 3); end
      if (i < 3) for (int g = 0; g < 3; g++) begin
        drive(1'b0, nonmark());
        n_cmp++; if (out_valid !== 1'b0 || first_sample_pulse !== 1'b0 || data_out !== e_dout) begin
          n_err++; $display("FAIL gap_idle got ov=%b fsp=%b dout=%0h expected 0/0/%0h",
            out_valid, first_sample_pulse, data_out, e_dout); end
      end
    end
  endtask

  task automatic test_lock_loss();
    do_reset(1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, mark(8'hF8));
    for (int i = 0; i < NUM_CH; i++) drive(1'b1, nonmark());
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, nonmark());
      n_cmp++; if (lock_lost_pulse !== (i == 1) || locked !== (i == 0)) begin
        n_err++; $display("FAIL loss[%0d] got lost=%b locked=%b expected %b/%b",
          i, lock_lost_pulse, locked, i == 1, i == 0); end
    end
`ifdef FCS_STATS_EN
    n_cmp++; if (lock_loss_cnt !== 16'd1 || frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL loss_stats got losses=%0d frames=%0d expected 1/1", lock_loss_cnt, frame_cnt); end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, mark(8'hB8));
    for (int i = 0; i < 2; i++) drive(1'b1, nonmark());
    do_reset(1'b1, nonmark());
    n_cmp++; if ({out_valid, first_sample_pulse, ch_valid, locked, lock_lost_pulse} !== 5'b0
                 || data_out !== '0 || ch_idx !== '0) begin
      n_err++; $display("FAIL midrst got flags=%b dout=%0h idx=%0d expected all 0",
        {out_valid, first_sample_pulse, ch_valid, locked, lock_lost_pulse}, data_out, ch_idx); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mark(8'hB8));
      n_cmp++; if (first_sample_pulse !== (i == 3) || ch_valid !== 1'b0) begin
        n_err++; $display("FAIL relock[%0d] got fsp=%b chv=%b expected %b/0", i, first_sample_pulse, ch_valid, i == 3); end
    end
  endtask

  task automatic test_random();
    logic v;
    logic [DATA_W-1:0] d;
    do_reset(1'b0, '0);
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 9) < 8);
      d = ($urandom_range(0, 9) < 6) ? mark($urandom_range(0, 1) ? 8'hB8 : 8'hF8) : nonmark();
      drive(v, d);
      n_cmp++; if (out_valid !== e_ov || first_sample_pulse !== e_fsp || ch_valid !== e_chv
                   || lock_lost_pulse !== e_lost || locked !== e_lock) begin
        n_err++; $display("FAIL rand_flags[%0d] got ov/fsp/chv/lost/lock=%b%b%b%b%b expected %b%b%b%b%b", n,
          out_valid, first_sample_pulse, ch_valid, lock_lost_pulse, locked, e_ov, e_fsp, e_chv, e_lost, e_lock); end
      n_cmp++; if (data_out !== e_dout || (e_chv && ch_idx !== e_idx)) begin
        n_err++; $display("FAIL rand_data[%0d] got dout=%0h idx=%0d expected %0h/%0d", n, data_out, ch_idx, e_dout, e_idx); end
      n_cmp++; if (first_sample_pulse && ch_valid) begin
        n_err++; $display("FAIL rand_excl[%0d] got fsp=1 chv=1 expected not both", n); end
`ifdef FCS_STATS_EN
      n_cmp++; if (frame_cnt !== 16'(m_frames) || lock_loss_cnt !== 16'(m_losses)) begin
        n_err++; $display("FAIL rand_stats[%0d] got %0d/%0d expected %0d/%0d", n, frame_cnt, lock_loss_cnt, m_frames, m_losses); end
`endif
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_lock();
    test_frame();
    test_partial();
    test_gaps();
    test_lock_loss();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
